// File: rtl/commu_tx_ser.sv
// Serial word transmitter: start bit, DATA_W data bits MSB-first, optional even parity, stop bit.
// Latency: start level on tx_out one cycle after fire_tx; done_tx at 1 + NB*(cfg_div+1) cycles.
// Backpressure: none; fire_tx is dropped while busy_tx or done_tx is high. COMMU_TX_PARITY_EN adds parity.
module commu_tx_ser #(
    parameter int   DATA_W   = 16,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              fire_tx,
    input  logic [DATA_W-1:0] data_tx,
    input  logic [15:0]       cfg_div,
    output logic              done_tx,
    output logic              busy_tx,
    output logic              tx_out
);

    localparam int             BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_W - 1);

`ifdef COMMU_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [15:0]       div_q;
    logic [15:0]       baud_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              bit_end;
    logic              accept;
    logic              tx_nxt;
`ifdef COMMU_TX_PARITY_EN
    logic              par_q;
`endif

    // A bit period ends when the baud counter reaches the latched divider.
    assign bit_end = (baud_cnt == div_q);
    assign accept  = (state == S_IDLE) && fire_tx;
    assign done_tx = (state == S_DONE);
    assign busy_tx = (state != S_IDLE);

    // Next-state and next shift-register contents.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        case (state)
            S_IDLE: begin
                if (fire_tx) begin
                    state_nxt = S_START;
                    shreg_nxt = data_tx;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                    if (bit_cnt == BIT_LAST) begin
`ifdef COMMU_TX_PARITY_EN
                        state_nxt = S_PAR;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef COMMU_TX_PARITY_EN
            S_PAR: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level follows the state being entered, so tx_out is glitch-free and one register deep.
    always_comb begin
        tx_nxt = IDLE_LVL;
        case (state_nxt)
            S_START: tx_nxt = ~IDLE_LVL;
            S_DATA:  tx_nxt = shreg_nxt[DATA_W-1];
`ifdef COMMU_TX_PARITY_EN
            S_PAR:   tx_nxt = par_q;
`endif
            default: tx_nxt = IDLE_LVL;
        endcase
    end

    // FSM state, shift register and serial line registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            shreg  <= '0;
            tx_out <= IDLE_LVL;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            tx_out <= tx_nxt;
        end
    end

    // Divider latch and baud/bit counters; the divider is sampled only at accept.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (accept) begin
                div_q <= cfg_div;
            end
            if (state == S_IDLE || state == S_DONE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (accept) begin
                bit_cnt <= '0;
            end else if (state == S_DATA && bit_end) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

`ifdef COMMU_TX_PARITY_EN
    // Even parity of the accepted word, captured before the shift register starts moving.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^data_tx;
        end
    end
`endif

endmodule

// File: tb/tb_commu_tx_ser.sv
// Bench for commu_tx_ser: random and directed frames against a bit-list reference model.
// A monitor pops expected frames when a start bit appears and checks every line cycle.
// Frames fired while the model says the transmitter is occupied are expected to vanish.
module tb_commu_tx_ser;

    localparam int DW = 16;
`ifdef COMMU_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        fire_tx = 1'b0;
    logic [15:0] data_tx = '0;
    logic [15:0] cfg_div = '0;
    logic        done_tx;
    logic        busy_tx;
    logic        tx_out;

    commu_tx_ser dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .fire_tx (fire_tx),
        .data_tx (data_tx),
        .cfg_div (cfg_div),
        .done_tx (done_tx),
        .busy_tx (busy_tx),
        .tx_out  (tx_out)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          div;
        int          fire_cyc;
    } item_t;

    item_t exp_q[$];
    int    n_chk      = 0;
    int    n_fail     = 0;
    int    busy_until = 0;

    logic  in_frame = 1'b0;
    int    pos      = 0;
    item_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame as a list of line levels: start, data MSB-first, optional even parity, stop.
    function automatic logic exp_bit(input logic [15:0] d, input int idx);
        logic [15:0] w;
        w = d;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return w[DW - idx];
`ifdef COMMU_TX_PARITY_EN
        if (idx == DW + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    // Monitor: line idle -> wait for start bit; in frame -> check every cycle through done.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                chk("rst_tx", 32'(tx_out), 32'd1);
                chk("rst_done", 32'(done_tx), 32'd0);
                chk("rst_busy", 32'(busy_tx), 32'd0);
                in_frame = 1'b0;
            end else begin
                if (!in_frame) begin
                    if (tx_out !== 1'b1) begin
                        if (exp_q.size() == 0) begin
                            chk("spurious_start", 32'(tx_out), 32'd1);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("start_lat", 32'(cyc), 32'(cur.fire_cyc + 1));
                            in_frame = 1'b1;
                            pos      = 0;
                        end
                    end else begin
                        chk("idle_done", 32'(done_tx), 32'd0);
                        chk("idle_busy", 32'(busy_tx), 32'd0);
                    end
                end
                if (in_frame) begin
                    if (pos < NB * (cur.div + 1)) begin
                        chk("tx_bit", 32'(tx_out), 32'(exp_bit(cur.data, pos / (cur.div + 1))));
                        chk("frame_done", 32'(done_tx), 32'd0);
                        chk("frame_busy", 32'(busy_tx), 32'd1);
                        pos++;
                    end else begin
                        chk("done_tx", 32'(done_tx), 32'd1);
                        chk("done_line", 32'(tx_out), 32'd1);
                        chk("done_busy", 32'(busy_tx), 32'd1);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // One-cycle fire strobe; the model decides whether the transmitter is free to take it.
    task automatic send(input logic [15:0] d, input int div);
        fire_tx = 1'b1;
        data_tx = d;
        cfg_div = 16'(div);
        if (cyc >= busy_until) begin
            exp_q.push_back('{data: d, div: div, fire_cyc: cyc});
            busy_until = cyc + 2 + NB * (div + 1);
        end
        tick(1);
        fire_tx = 1'b0;
        data_tx = 16'($urandom);
        cfg_div = 16'($urandom);
    endtask

    task automatic wait_free();
        while (cyc < busy_until) tick(1);
    endtask

    initial begin
        int f;
        // Reset held with fire asserted: line must stay idle.
        rst_n   = 1'b0;
        fire_tx = 1'b1;
        data_tx = 16'hFFFF;
        tick(3);
        fire_tx = 1'b0;
        rst_n   = 1'b1;
        tick(2);

        send(16'hA55A, 0);
        wait_free();
        tick(1);

        send(16'h0001, 3);
        wait_free();
        tick(2);

        // Second fire mid-frame must be ignored.
        send(16'h1234, 2);
        tick(10);
        send(16'hFFFF, 2);
        wait_free();
        tick(1);

        // Fire during the done cycle is dropped, fire right after is accepted.
        send(16'h1234, 1);
        while (cyc < busy_until - 1) tick(1);
        send(16'hFFFF, 1);
        send(16'h5678, 1);
        wait_free();
        tick(1);

        // Reset while data bit 7 is on the line, then a clean frame.
        f = cyc;
        send(16'hC3A5, 2);
        while (cyc < f + 1 + 8 * 3 + 1) tick(1);
        rst_n = 1'b0;
        exp_q.delete();
        busy_until = 0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send(16'h3C5A, 2);
        wait_free();

        // Random frames, random gaps (including back-to-back) and stray fires.
        for (int i = 0; i < 25; i++) begin
            send(16'($urandom), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) begin
                tick(int'($urandom_range(1, 6)));
                send(16'($urandom), int'($urandom_range(0, 4)));
            end
            wait_free();
            tick(int'($urandom_range(0, 3)));
        end

        // Drain with a bound.
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || in_frame); i++) tick(1);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_frame", 32'(in_frame), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
